// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and
// default constants.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;  // sll $0,$0,0
    localparam int unsigned PC_INC_DEF    = 4;

endpackage

// File: rtl/fetch_stage_pipe_skid_buf.sv
// One-entry skid buffer holding {instr, pc, pc4} while the IF/ID register
// is stalled. Priority: clear over load over unload.
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            unload_i,
    input  logic            clear_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc4_i,
    output logic            valid_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc4_o
);

    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc4_q, pc4_d;

    // Next-state selection for the buffered entry
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
            pc4_d   = pc4_i;
        end else if (unload_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Buffer storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= 32'h0000_0000;
            pc_q    <= {XLEN{1'b0}};
            pc4_q   <= {XLEN{1'b0}};
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_stage_pipe.sv
// IF stage: owns the PC, runs the imem request/ready handshake and loads IF/ID.
// Optional build macro FETCH_PERF_CNT_EN adds saturating fetch/bubble counters.
module fetch_stage_pipe
    import fetch_pkg::*;
#(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = {XLEN{1'b0}},
    parameter int unsigned      PC_INC    = PC_INC_DEF,
    parameter logic [31:0]      NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            if_id_valid,
    output logic [31:0]     if_id_instr,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_bubbles
`endif
);

    localparam logic [XLEN-1:0] PC_INC_W = XLEN'(PC_INC);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic [31:0]     ifid_instr_q, ifid_instr_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
    logic [XLEN-1:0] ifid_pc4_q, ifid_pc4_d;

    logic            skid_load_s, skid_unload_s, skid_clear_s;
    logic            skid_valid_s;
    logic [31:0]     skid_instr_s;
    logic [XLEN-1:0] skid_pc_s, skid_pc4_s;
    logic            fetch_load_s;
    logic            accept_s;
    logic [XLEN-1:0] req_pc_inc_s;

    assign accept_s     = !ifid_valid_q || !stall;
    assign req_pc_inc_s = req_pc_q + PC_INC_W;

    fetch_skid_buf #(.XLEN(XLEN)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load_i   (skid_load_s),
        .unload_i (skid_unload_s),
        .clear_i  (skid_clear_s),
        .instr_i  (imem_rdata),
        .pc_i     (req_pc_q),
        .pc4_i    (req_pc_inc_s),
        .valid_o  (skid_valid_s),
        .instr_o  (skid_instr_s),
        .pc_o     (skid_pc_s),
        .pc4_o    (skid_pc4_s)
    );

    // FSM next state, PC update and IF/ID load decisions
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        ifid_valid_d  = ifid_valid_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_pc4_d    = ifid_pc4_q;
        skid_load_s   = 1'b0;
        skid_unload_s = 1'b0;
        skid_clear_s  = 1'b0;
        fetch_load_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                if (redirect_valid) begin
                    req_pc_d = redirect_pc;
                end else begin
                    req_pc_d = req_pc_q;
                end
            end
            ST_REQ: begin
                if (redirect_valid) begin
                    // An outstanding request cannot be aborted; drain it first.
                    if (imem_ready) begin
                        req_pc_d = redirect_pc;
                        state_d  = ST_REQ;
                    end else begin
                        state_d  = ST_DRAIN;
                    end
                end else if (imem_ready) begin
                    pc_d     = req_pc_inc_s;
                    req_pc_d = req_pc_inc_s;
                    if (accept_s) begin
                        ifid_valid_d = 1'b1;
                        ifid_instr_d = imem_rdata;
                        ifid_pc_d    = req_pc_q;
                        ifid_pc4_d   = req_pc_inc_s;
                        fetch_load_s = 1'b1;
                    end else begin
                        skid_load_s  = 1'b1;
                        state_d      = ST_HOLD;
                    end
                end else begin
                    if (!stall) begin
                        ifid_valid_d = 1'b0;
                    end else begin
                        ifid_valid_d = ifid_valid_q;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    req_pc_d = redirect_pc;
                    state_d  = ST_REQ;
                end else if (!stall) begin
                    ifid_valid_d  = skid_valid_s;
                    ifid_instr_d  = skid_instr_s;
                    ifid_pc_d     = skid_pc_s;
                    ifid_pc4_d    = skid_pc4_s;
                    skid_unload_s = 1'b1;
                    fetch_load_s  = skid_valid_s;
                    state_d       = ST_REQ;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (imem_ready) begin
                    req_pc_d = redirect_valid ? redirect_pc : pc_q;
                    state_d  = ST_REQ;
                end else begin
                    state_d  = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A redirect flushes IF/ID and the skid in every state.
        if (redirect_valid) begin
            pc_d         = redirect_pc;
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
            skid_clear_s = 1'b1;
        end else begin
            skid_clear_s = 1'b0;
        end
    end

    // State, PC and IF/ID registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            req_pc_q     <= RESET_PC;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= {XLEN{1'b0}};
            ifid_pc4_q   <= {XLEN{1'b0}};
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
        end
    end

    assign imem_req    = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    assign imem_addr   = req_pc_q;
    assign if_id_valid = ifid_valid_q;
    assign if_id_instr = ifid_instr_q;
    assign if_id_pc    = ifid_pc_q;
    assign if_id_pc4   = ifid_pc4_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_bubbles_q;

    // Saturating fetch and bubble counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q <= 32'h0000_0000;
            perf_bubbles_q <= 32'h0000_0000;
        end else begin
            if (fetch_load_s && (perf_fetched_q != 32'hFFFF_FFFF)) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end else begin
                perf_fetched_q <= perf_fetched_q;
            end
            if ((state_q != ST_IDLE) && !ifid_valid_q && (perf_bubbles_q != 32'hFFFF_FFFF)) begin
                perf_bubbles_q <= perf_bubbles_q + 32'd1;
            end else begin
                perf_bubbles_q <= perf_bubbles_q;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_stage_pipe.sv
// Directed self-checking bench for fetch_stage_pipe (RESET_PC = 0x40).
// Memory model returns addr + 0x1000_0000 as the instruction word.
module tb_fetch_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr + 32'h1000_0000;

    fetch_stage_pipe #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0040)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc4      (if_id_pc4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_bubbles   (perf_bubbles)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        stall          = 1'b0;
        imem_ready     = 1'b1;
        tick();
        tick();
        check_val("rst_req",   {31'd0, imem_req},    32'h0);
        check_val("rst_addr",  imem_addr,            32'h0000_0040);
        check_val("rst_valid", {31'd0, if_id_valid}, 32'h0);
        check_val("rst_instr", if_id_instr,          32'h0000_0000);
        check_val("rst_pc",    if_id_pc,             32'h0);
        check_val("rst_pc4",   if_id_pc4,            32'h0);

        // Streaming with ready tied high
        rst = 1'b0;
        tick();
        check_val("idle_req",  {31'd0, imem_req},    32'h1);
        check_val("idle_addr", imem_addr,            32'h0000_0040);
        check_val("idle_valid",{31'd0, if_id_valid}, 32'h0);
        tick();
        check_val("s0_addr",  imem_addr,            32'h0000_0044);
        check_val("s0_pc",    if_id_pc,             32'h0000_0040);
        check_val("s0_pc4",   if_id_pc4,            32'h0000_0044);
        check_val("s0_instr", if_id_instr,          32'h1000_0040);
        check_val("s0_valid", {31'd0, if_id_valid}, 32'h1);
        tick();
        check_val("s1_addr",  imem_addr,            32'h0000_0048);
        check_val("s1_pc4",   if_id_pc4,            32'h0000_0048);
        check_val("s1_valid", {31'd0, if_id_valid}, 32'h1);
        tick();
        check_val("s2_addr",  imem_addr,            32'h0000_004C);
        check_val("s2_pc4",   if_id_pc4,            32'h0000_004C);
        check_val("s2_instr", if_id_instr,          32'h1000_0048);

        // Ready three cycles after each request
        for (int k = 0; k < 2; k++) begin
            logic [31:0] base;
            base = 32'h0000_004C + 32'(4 * k);
            imem_ready = 1'b0;
            tick();
            check_val("slow_bubble", {31'd0, if_id_valid}, 32'h0);
            check_val("slow_addr0",  imem_addr,            base);
            tick();
            check_val("slow_addr1",  imem_addr,            base);
            imem_ready = 1'b1;
            tick();
            check_val("slow_valid",  {31'd0, if_id_valid}, 32'h1);
            check_val("slow_pc",     if_id_pc,             base);
            check_val("slow_next",   imem_addr,            base + 32'h4);
        end

        // Response arrives while IF/ID full and stalled -> skid
        stall = 1'b1;
        tick();
        check_val("hold_req",   {31'd0, imem_req},    32'h0);
        check_val("hold_pc",    if_id_pc,             32'h0000_0050);
        check_val("hold_valid", {31'd0, if_id_valid}, 32'h1);
        check_val("hold_addr",  imem_addr,            32'h0000_0058);
        imem_ready = 1'b0;
        tick();
        check_val("hold2_req",  {31'd0, imem_req},    32'h0);
        check_val("hold2_pc",   if_id_pc,             32'h0000_0050);
        stall = 1'b0;
        tick();
        check_val("skid_pc",    if_id_pc,             32'h0000_0054);
        check_val("skid_instr", if_id_instr,          32'h1000_0054);
        check_val("skid_req",   {31'd0, imem_req},    32'h1);
        check_val("skid_addr",  imem_addr,            32'h0000_0058);
        imem_ready = 1'b1;
        tick();
        check_val("post_pc",    if_id_pc,             32'h0000_0058);
        check_val("post_addr",  imem_addr,            32'h0000_005C);

        // Redirect with a request outstanding -> DRAIN
        imem_ready = 1'b0;
        tick();
        check_val("pre_rd_valid", {31'd0, if_id_valid}, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        check_val("drain_req",   {31'd0, imem_req},    32'h1);
        check_val("drain_addr",  imem_addr,            32'h0000_005C);
        check_val("drain_valid", {31'd0, if_id_valid}, 32'h0);
        check_val("drain_instr", if_id_instr,          32'h0000_0000);
        tick();
        check_val("drain_addr2", imem_addr,            32'h0000_005C);
        imem_ready = 1'b1;
        tick();
        check_val("drain_done_addr",  imem_addr,            32'h0000_0100);
        check_val("drain_done_valid", {31'd0, if_id_valid}, 32'h0);
        tick();
        check_val("tgt_pc",    if_id_pc,             32'h0000_0100);
        check_val("tgt_instr", if_id_instr,          32'h1000_0100);
        check_val("tgt_valid", {31'd0, if_id_valid}, 32'h1);
        check_val("tgt_addr",  imem_addr,            32'h0000_0104);

        // Redirect with same-cycle stall and imem_ready
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        check_val("rs_valid", {31'd0, if_id_valid}, 32'h0);
        check_val("rs_instr", if_id_instr,          32'h0000_0000);
        check_val("rs_addr",  imem_addr,            32'h0000_0200);
        check_val("rs_req",   {31'd0, imem_req},    32'h1);
        tick();
        check_val("rs_pc",    if_id_pc,             32'h0000_0200);
        check_val("rs_v2",    {31'd0, if_id_valid}, 32'h1);

        // PC wrap at top of address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check_val("wrap_addr0", imem_addr,   32'hFFFF_FFFC);
        tick();
        check_val("wrap_pc",    if_id_pc,    32'hFFFF_FFFC);
        check_val("wrap_pc4",   if_id_pc4,   32'h0000_0000);
        check_val("wrap_addr",  imem_addr,   32'h0000_0000);
        check_val("wrap_instr", if_id_instr, 32'h0FFF_FFFC);

        // Asynchronous reset while draining
        imem_ready = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        tick();
        redirect_valid = 1'b0;
        check_val("pre_rst_addr", imem_addr, 32'h0000_0000);
        check_val("pre_rst_pc",   if_id_pc,  32'hFFFF_FFFC);
        #1;
        rst = 1'b1;
        #1;
        check_val("arst_req",   {31'd0, imem_req},    32'h0);
        check_val("arst_addr",  imem_addr,            32'h0000_0040);
        check_val("arst_valid", {31'd0, if_id_valid}, 32'h0);
        check_val("arst_instr", if_id_instr,          32'h0000_0000);
        check_val("arst_pc",    if_id_pc,             32'h0);
        check_val("arst_pc4",   if_id_pc4,            32'h0);
        tick();
        rst = 1'b0;
        tick();
        check_val("restart_req",  {31'd0, imem_req}, 32'h1);
        check_val("restart_addr", imem_addr,         32'h0000_0040);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
